comma_lock_ctrl: RTL

- Receive-side symbol-lock controller. Sits after the K28.5 comma detector and the 8b/10b decoder.
- Counts comma pulses to gate the aligner (align_en) during acquisition. Declares lock after LOCK_COMMAS consecutive commas with valid spacing.
- Monitors code errors to drop lock and re-acquire. Also produces the qualified rx_valid strobe for downstream elastic buffer / PIPE logic.

---
 rtl/comma_lock_pkg.sv | 17 +
 rtl/sat_counter.sv | 25 ++
 rtl/comma_lock_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/comma_lock_pkg.sv
// Shared state encoding and default tuning for the receive symbol-lock controller.
package comma_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    CHECK   = 2'b11
  } lock_state_t;

  localparam int unsigned LOCK_COMMAS_DEF   = 3;
  localparam int unsigned COMMA_GAP_MAX_DEF = 64;
  localparam int unsigned ERR_LIMIT_DEF     = 4;
  localparam int unsigned GOOD_RECOVER_DEF  = 4;
  localparam int unsigned CNT_W_DEF         = 7;

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that sticks at all-ones and at zero; synchronous clear has priority.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/comma_lock_ctrl.sv
// Receive symbol-lock controller: comma-counted acquisition, error-budgeted lock hold.
// Optional macro COMMA_LOCK_STATS_EN adds a saturating lock_loss_cnt output.
module comma_lock_ctrl
  import comma_lock_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS   = LOCK_COMMAS_DEF,
  parameter int unsigned COMMA_GAP_MAX = COMMA_GAP_MAX_DEF,
  parameter int unsigned ERR_LIMIT     = ERR_LIMIT_DEF,
  parameter int unsigned GOOD_RECOVER  = GOOD_RECOVER_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sym_valid,
  input  logic        comma_pulse,
  input  logic        code_err,
  output logic        align_en,
  output logic        rx_locked,
  output logic        rx_valid,
  output logic        lock_lost,
  output logic [1:0]  state
`ifdef COMMA_LOCK_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt
`endif
);

  localparam int unsigned CC_W   = $clog2(LOCK_COMMAS + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GOOD_W = $clog2(GOOD_RECOVER + 1);

  lock_state_t       cur_state;
  logic [CC_W-1:0]   comma_cnt;
  logic [CNT_W-1:0]  gap_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              err_clr, err_inc, err_dec;
  logic              sym_ok, sym_bad, is_locked;

  assign sym_ok    = sym_valid & ~code_err;
  assign sym_bad   = sym_valid & code_err;
  assign is_locked = (cur_state == LOCKED) || (cur_state == CHECK);
  assign state     = cur_state;

  // err_cnt lives in sat_counter, so its controls mirror the FSM's CHECK decisions
  always_comb begin
    err_clr = 1'b0;
    err_inc = 1'b0;
    err_dec = 1'b0;
    if (!en) begin
      err_clr = 1'b1;
    end else begin
      case (cur_state)
        IDLE:   err_clr = 1'b1;
        LOCKED: err_inc = sym_bad;
        CHECK: begin
          if (sym_bad) begin
            if (err_cnt == ERR_W'(ERR_LIMIT - 1)) err_clr = 1'b1;
            else                                  err_inc = 1'b1;
          end else if (sym_ok && good_cnt == GOOD_W'(GOOD_RECOVER - 1)) begin
            err_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (err_clr),
    .inc   (err_inc),
    .dec   (err_dec),
    .cnt   (err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      comma_cnt <= '0;
      gap_cnt   <= '0;
      good_cnt  <= '0;
      align_en  <= 1'b0;
      rx_locked <= 1'b0;
      rx_valid  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      rx_valid  <= en && is_locked && sym_ok;
      if (!en) begin
        cur_state <= IDLE;
        comma_cnt <= '0;
        gap_cnt   <= '0;
        good_cnt  <= '0;
        align_en  <= 1'b0;
        rx_locked <= 1'b0;
        lock_lost <= is_locked;
      end else begin
        case (cur_state)
          IDLE: begin
            cur_state <= ACQUIRE;
            comma_cnt <= '0;
            gap_cnt   <= '0;
            good_cnt  <= '0;
            align_en  <= 1'b1;
            rx_locked <= 1'b0;
          end
          ACQUIRE: begin
            if (sym_bad) begin
              comma_cnt <= '0;
              gap_cnt   <= '0;
            end else if (sym_valid && comma_pulse) begin
              gap_cnt <= '0;
              if (comma_cnt == CC_W'(LOCK_COMMAS - 1)) begin
                cur_state <= LOCKED;
                comma_cnt <= '0;
                align_en  <= 1'b0;
                rx_locked <= 1'b1;
              end else begin
                comma_cnt <= comma_cnt + 1'b1;
              end
            end else if (sym_valid) begin
              if (gap_cnt == CNT_W'(COMMA_GAP_MAX - 1)) begin
                comma_cnt <= '0;
                gap_cnt   <= '0;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (sym_bad) begin
              cur_state <= CHECK;
              good_cnt  <= '0;
            end
          end
          CHECK: begin
            if (sym_bad) begin
              good_cnt <= '0;
              if (err_cnt == ERR_W'(ERR_LIMIT - 1)) begin
                cur_state <= ACQUIRE;
                comma_cnt <= '0;
                gap_cnt   <= '0;
                align_en  <= 1'b1;
                rx_locked <= 1'b0;
                lock_lost <= 1'b1;
              end
            end else if (sym_ok) begin
              if (good_cnt == GOOD_W'(GOOD_RECOVER - 1)) begin
                good_cnt <= '0;
                if (err_cnt == ERR_W'(1)) cur_state <= LOCKED;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end
          default: cur_state <= IDLE;
        endcase
      end
    end
  end

`ifdef COMMA_LOCK_STATS_EN
  sat_counter #(.W(16)) u_loss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (lock_lost),
    .dec   (1'b0),
    .cnt   (lock_loss_cnt)
  );
`endif

endmodule
